// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the seq_mult shift-and-add multiplier.
package seq_mult_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step-counter width: must hold the values 0..width
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage : seq_mult_pkg

// File: rtl/full_adder.sv
// Single-bit full-adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule : full_adder

// File: rtl/seq_mult_rca_adder.sv
// N-bit ripple-carry adder chained from full-adder cells.
module rca_adder #(
    parameter int unsigned N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    logic [N:0] carry;

    assign carry[0] = ci;
    assign co       = carry[N];

    // Ripple chain, LSB first
    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (s[i]),
            .co (carry[i+1])
        );
    end

endmodule : rca_adder

// File: rtl/seq_mult.sv
// Radix-2 shift-and-add multiplier: WIDTH steps per product, start/busy/done handshake.
// Build option: define SEQ_MULT_SIGNED_EN for two's-complement operands and product.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam int unsigned AW    = WIDTH + 1;

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mq;
    logic [CNT_W-1:0]   cnt;

    logic               last_c;
    logic [AW-1:0]      add_a_c;
    logic [AW-1:0]      add_b_c;
    logic               add_ci_c;
    logic [AW-1:0]      sum_c;
    logic               unused_carry;
    logic [WIDTH-1:0]   acc_nxt_c;
    logic [WIDTH-1:0]   mq_nxt_c;
    logic               busy_d_c;
    logic               done_d_c;

    assign last_c = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

    // Adder operands for one step; signed build subtracts mcand on the final step
    always_comb begin
        add_a_c  = '0;
        add_b_c  = '0;
        add_ci_c = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
        add_a_c = {acc[WIDTH-1], acc};
        if (mq[0]) begin
            if (last_c) begin
                add_b_c  = ~{mcand[WIDTH-1], mcand};
                add_ci_c = 1'b1;
            end else begin
                add_b_c  = {mcand[WIDTH-1], mcand};
            end
        end
`else
        add_a_c = {1'b0, acc};
        if (mq[0]) begin
            add_b_c = {1'b0, mcand};
        end
`endif
    end

    // The WIDTH+1-bit sum already holds the step's carry, so the adder carry-out is not needed
    rca_adder #(
        .N (AW)
    ) u_adder (
        .a  (add_a_c),
        .b  (add_b_c),
        .ci (add_ci_c),
        .s  (sum_c),
        .co (unused_carry)
    );

    assign acc_nxt_c = sum_c[AW-1:1];
    assign mq_nxt_c  = {sum_c[0], mq[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_c) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded from the upcoming state so they can be registered
    always_comb begin
        busy_d_c = 1'b0;
        done_d_c = 1'b0;
        if (next_state != IDLE) busy_d_c = 1'b1;
        if (next_state == DONE) done_d_c = 1'b1;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand <= '0;
            acc   <= '0;
            mq    <= '0;
            cnt   <= '0;
            p     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            busy <= busy_d_c;
            done <= done_d_c;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= a;
                        mq    <= b;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_nxt_c;
                    mq  <= mq_nxt_c;
                    cnt <= cnt + CNT_W'(1);
                    if (last_c) begin
                        p <= {acc_nxt_c, mq_nxt_c};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : seq_mult

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult at WIDTH=4 (directed) and WIDTH=8 (random sweep).
module tb_seq_mult;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       busy4;
    logic       done4;
    logic [7:0] p4;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8;
    logic        done8;
    logic [15:0] p8;

    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    seq_mult #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .busy  (busy4),
        .done  (done4),
        .p     (p4)
    );

    seq_mult #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .p     (p8)
    );

    // Reference product: plain integer multiply, truncated to 2*w bits
    function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint pr;
        sa = longint'(a);
        sb = longint'(b);
`ifdef SEQ_MULT_SIGNED_EN
        if (a[w-1]) sa = sa - (longint'(1) << w);
        if (b[w-1]) sb = sb - (longint'(1) << w);
`endif
        pr = sa * sb;
        return 64'(pr) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=4 operation with a one-cycle start; waits (bounded) for done
    task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b);
        int n;
        a4 = a;
        b4 = b;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        a4 = ~a;
        b4 = ~b;
        chk({tag, "_busy"}, 64'(busy4), 64'd1);
        n = 0;
        while (!done4 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, 64'(done4), 64'd1);
        chk({tag, "_steps"}, 64'(n), 64'd4);
        chk({tag, "_p"}, 64'(p4), model(4, 32'(a), 32'(b)));
        tick();
        chk({tag, "_idle"}, 64'({busy4, done4}), 64'd0);
    endtask

    initial begin
        logic [63:0] q[$];
        logic [63:0] expv;
        int ops;
        int dones;
        int guard;
        logic [7:0] ra;
        logic [7:0] rb;

        // Reset state
        #12;
        chk("rst_busy4", 64'(busy4), 64'd0);
        chk("rst_done4", 64'(done4), 64'd0);
        chk("rst_p4",    64'(p4),    64'd0);
        chk("rst_p8",    64'({busy8, done8, p8}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 3*5 with detailed cycle timing
        a4 = 4'd3;
        b4 = 4'd5;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("t1_busy_e0", 64'({busy4, done4}), 64'b10);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("t1_run", 64'({busy4, done4}), 64'b10);
        end
        tick();
        chk("t1_done_e4", 64'({busy4, done4}), 64'b11);
        chk("t1_p", 64'(p4), model(4, 32'd3, 32'd5));
`ifndef SEQ_MULT_SIGNED_EN
        chk("t1_p_const", 64'(p4), 64'd15);
`endif
        tick();
        chk("t1_after", 64'({busy4, done4}), 64'b00);
        chk("t1_p_held", 64'(p4), model(4, 32'd3, 32'd5));

        run4("max", 4'd15, 4'd15);
`ifndef SEQ_MULT_SIGNED_EN
        chk("max_const", 64'(p4), 64'd225);
`endif
        run4("zero", 4'd0, 4'd9);
        chk("zero_const", 64'(p4), 64'd0);

        // start pulses during RUN are ignored
        a4 = 4'd5;
        b4 = 4'd3;
        start4 = 1'b1;
        tick();
        a4 = 4'd9;
        b4 = 4'd11;
        tick();
        a4 = 4'd13;
        b4 = 4'd6;
        tick();
        start4 = 1'b0;
        tick();
        chk("ign_no_done_yet", 64'(done4), 64'd0);
        tick();
        chk("ign_done", 64'(done4), 64'd1);
        chk("ign_p", 64'(p4), model(4, 32'd5, 32'd3));
        tick();
        chk("ign_idle", 64'({busy4, done4}), 64'd0);

        // Asynchronous reset mid-RUN
        a4 = 4'd2;
        b4 = 4'd7;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy4), 64'd0);
        chk("arst_done", 64'(done4), 64'd0);
        chk("arst_p", 64'(p4), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("arst_no_done", 64'({busy4, done4}), 64'd0);
        end
        run4("post_rst", 4'd6, 4'd7);
`ifndef SEQ_MULT_SIGNED_EN
        chk("post_rst_const", 64'(p4), 64'd42);
`endif

`ifdef SEQ_MULT_SIGNED_EN
        run4("s_m3x5", 4'hD, 4'd5);
        chk("s_m3x5_const", 64'(p4), 64'hF1);
        run4("s_m8xm8", 4'h8, 4'h8);
        chk("s_m8xm8_const", 64'(p4), 64'h40);
        run4("s_7xm1", 4'd7, 4'hF);
        chk("s_7xm1_const", 64'(p4), 64'hF9);
`endif

        // WIDTH=8 random sweep with start held high
        ops = 0;
        dones = 0;
        guard = 0;
        while (dones < 1000 && guard < 20000) begin
            if (!busy8) begin
                if (ops < 1000) begin
                    ra = 8'($urandom);
                    rb = 8'($urandom);
                    if (ops == 0) begin ra = 8'hFF; rb = 8'hFF; end
                    if (ops == 1) begin ra = 8'h80; rb = 8'h80; end
                    a8 = ra;
                    b8 = rb;
                    q.push_back(model(8, 32'(ra), 32'(rb)));
                    start8 = 1'b1;
                    ops++;
                end else begin
                    start8 = 1'b0;
                end
            end else begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
            tick();
            guard++;
            if (done8) begin
                dones++;
                if (q.size() == 0) begin
                    chk("sweep_extra_done", 64'(dones), 64'(ops));
                end else begin
                    expv = q.pop_front();
                    chk("sweep_p", 64'(p8), expv);
                end
            end
        end
        start8 = 1'b0;
        chk("sweep_ops", 64'(ops), 64'd1000);
        chk("sweep_dones", 64'(dones), 64'd1000);
        chk("sweep_queue_empty", 64'(q.size()), 64'd0);
        tick();
        tick();
        chk("sweep_idle", 64'({busy8, done8}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule : tb_seq_mult
